// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial subtractor: computes A - B one bit per cycle through a single
// full-adder slice evaluating A + ~B + 1, with a registered carry. Intended as
// a low-area multi-cycle execution unit beside a combinational ALU.
//
// Handshake: start_i is accepted in IDLE or DONE. busy_o is high for WIDTH
// cycles while bits are processed. done_o pulses for one cycle when the
// result is committed. Result outputs hold until the next commit.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf_o port (signed
// two's-complement overflow of A - B). Without it the port and logic are absent.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_i   synchronous, active-high reset
//   start_i   operation request (sampled only in IDLE or DONE)
//   a_i       minuend, captured on accepted start
//   b_i       subtrahend, captured on accepted start
//   busy_o    high while shifting (RUN)
//   done_o    one-cycle pulse when a result is committed
//   diff_o    registered A - B modulo 2^WIDTH
//   borrow_o  registered, 1 when unsigned A < B
//   zero_o    registered, 1 when diff_o == 0
//   ovf_o     registered signed overflow (SERIAL_SUB_OVF_EN only)

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             zero_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last_bit;
  logic             nb;
  logic             sum;
  logic             cout;
  logic [WIDTH-1:0] sr_shift;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // State register / datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StRun;
      StRun:  if (cnt_q == CntLast) state_d = StDone;
      StDone: state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

  // One full-adder slice on the current LSBs; B is inverted and the carry
  // starts at 1, so the slice adds A + ~B + 1.
  always_comb begin
    nb       = ~sb_q[0];
    sum      = sa_q[0] ^ nb ^ c_q;
    cout     = (sa_q[0] & nb) | (sa_q[0] & c_q) | (nb & c_q);
    sr_shift = {sum, sr_q[WIDTH-1:1]};
    accept   = start_i && ((state_q == StIdle) || (state_q == StDone));
    last_bit = (state_q == StRun) && (cnt_q == CntLast);
  end

  // Datapath next-state
  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    if (accept) begin
      sa_d  = a_i;
      sb_d  = b_i;
      sr_d  = '0;
      c_d   = 1'b1;
      cnt_d = '0;
    end else if (state_q == StRun) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      sr_d  = sr_shift;
      c_d   = cout;
      cnt_d = cnt_q + 1'b1;
    end

    // Commit on the edge that enters DONE, using the final slice outputs
    // directly so the result is visible together with done_o.
    if (last_bit) begin
      diff_d   = sr_shift;
      borrow_d = ~cout;
      zero_d   = (sr_shift == '0);
`ifdef SERIAL_SUB_OVF_EN
      // During the MSB cycle the carry flop holds the carry into the MSB.
      ovf_d    = c_q ^ cout;
`endif
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign zero_o   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing A − B one bit per cycle through a single full-adder slice (A + ~B + 1) with a registered carry. It sits beside the processor's combinational ALU as a low-area, multi-cycle execution unit. It uses a start/busy/done handshake and returns the difference plus borrow and zero flags. Results are held stable until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is committed
- diff  output  WIDTH  registered A − B, modulo 2^WIDTH
- borrow  output  1  registered; 1 when unsigned A < B
- zero  output  1  registered; 1 when diff == 0
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- The clock is clk and reset is synchronous, active-high, named reset, with a single clock domain.
- States:
  - IDLE: waiting for start.
  - RUN: shifting one bit per cycle.
  - DONE: commits the result and pulses done.
- Internal registers:
  - sa, sb: WIDTH-bit operand shift registers.
  - sr: WIDTH-bit result shift register.
  - c: 1-bit carry flop.
  - cnt: bit counter, $clog2(WIDTH) bits wide.
- Accepted start (IDLE or DONE with start=1):
  - Load sa←a and sb←b.
  - Set c←1, cnt←0, sr←0.
  - Go to RUN.
- Each RUN cycle:
  - s = sa[0] ^ ~sb[0] ^ c
  - c ← (sa[0]&~sb[0]) | (sa[0]&c) | (~sb[0]&c)
  - sa, sb shift right by 1.
  - sr ← {s, sr[WIDTH-1:1]}
  - cnt ← cnt+1.
- Leaving RUN: on the cycle where cnt == WIDTH−1, go to DONE.
- On entry to DONE, commit the outputs:
  - diff ← final sr
  - borrow ← ~final c
  - zero ← (final sr == 0)
- DONE lasts one cycle with done=1.
  - With start=1: re-enter RUN (back-to-back operation).
  - Otherwise: go to IDLE.
- start during RUN is ignored. Operands are not re-sampled.
- diff, borrow, zero (and ovf) change only at commit and hold otherwise.
- Reset values:
  - State IDLE.
  - busy=0, done=0, diff=0, borrow=0, zero=0, ovf=0.
  - Internal registers cleared.

## Timing
- start sampled high at edge 0 → RUN from edge 0.
- Bits are processed at edges 1..WIDTH. Outputs are committed at edge WIDTH.
- done is high between edges WIDTH and WIDTH+1.
- Latency is WIDTH+1 cycles from the start edge to the end of the done pulse.
- Throughput with start held high is one result per WIDTH+1 cycles. The next operation's operands are captured at the DONE-cycle edge.
- busy is high exactly WIDTH cycles per operation. busy and done are never high together.
- reset asserted mid-RUN: next edge → IDLE, all outputs 0, and the partial result is discarded.
- reset and start high on the same edge: reset wins.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - A carry-into-MSB flop is kept and the ovf port exists.
  - At commit, ovf ← carry_into_MSB ^ final c. This is two's-complement overflow of A − B.
- SERIAL_SUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, reset, then a=0x35, b=0x12, start one cycle:
  - busy is high for 8 cycles, then done pulses.
  - diff=0x23, borrow=0, zero=0.
- a=0x12, b=0x35:
  - diff=0xDD, borrow=1, zero=0.
- a=0x7A, b=0x7A:
  - diff=0x00, borrow=0, zero=1.
- Start held high with operand pairs (0x10,0x01) then (0x00,0x01):
  - Two done pulses 9 cycles apart.
  - Results are diff=0x0F, borrow=0, then diff=0xFF, borrow=1.
  - A start pulse mid-RUN is ignored.
- reset asserted at RUN cycle 4:
  - IDLE and all outputs 0 next cycle.
  - No done pulse.
  - A new start completes normally.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1.
  - a=0x05, b=0x03 → diff=0x02, ovf=0.
